// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, status/control register and level IRQ.
// Optional even-parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_peripheral #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned DIVISOR = CLK_FREQ / BAUD;
    localparam int unsigned DIV_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      TXD_ADDR = BASE_ADDR;
    localparam logic [31:0]      CON_ADDR = BASE_ADDR + 32'd8;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
`else
    localparam logic PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY
`endif
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] baud_cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       idx_next;
    logic [7:0]       shift;
    logic [7:0]       shift_next;
    logic             tx_next;
    logic             bit_end;
    logic             frame_end;
    logic             pop;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             busy;

    logic             irq_en;
    logic             done;
    logic             ovf;

    logic             txd_wr;
    logic             con_wr;
    logic             push;
    logic             ovf_set;
    logic [31:0]      con_value;
    logic             unused_bits;

    // Bus decode
    assign txd_wr  = MemWrite && (Address == TXD_ADDR);
    assign con_wr  = MemWrite && (Address == CON_ADDR);

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign busy    = (state != S_IDLE);

    // A pop in the same cycle frees a slot, so a store to a full FIFO still lands.
    assign push    = txd_wr && (!full || pop);
    assign ovf_set = txd_wr && full && !pop;

    assign con_value   = {25'b0, PARITY_FLAG, irq_en, done, ovf, empty, full, busy};
    assign unused_bits = ^{WriteData[31:8], WriteData[7:6], WriteData[2:0]};

    always_comb begin
        ReadData = 32'h0;
        if (MemRead && (Address == CON_ADDR)) begin
            ReadData = con_value;
        end
    end

    assign bit_end = (baud_cnt == DIV_LAST);

    // Transmit FSM: next state, counters and the registered line value
    always_comb begin
        state_next = state;
        cnt_next   = baud_cnt;
        idx_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;
        frame_end  = 1'b0;
        tx_next    = 1'b1;

        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr];
                    cnt_next   = '0;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = S_DATA;
                end else begin
                    cnt_next = baud_cnt + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = baud_cnt + DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = S_STOP;
                end else begin
                    cnt_next = baud_cnt + DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    frame_end  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = baud_cnt + DIV_W'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx stays glitch-free and registered
        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shift_next[idx_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = ^shift_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= cnt_next;
            bit_idx  <= idx_next;
            tx       <= tx_next;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_next;
        if (push) begin
            fifo_mem[wr_ptr] <= WriteData[7:0];
        end
    end

    // FIFO bookkeeping; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Status flags: a set in the same cycle as a write-1-to-clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (con_wr) begin
                irq_en <= WriteData[5];
            end
            if (frame_end) begin
                done <= 1'b1;
            end else if (con_wr && WriteData[4]) begin
                done <= 1'b0;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (con_wr && WriteData[3]) begin
                ovf <= 1'b0;
            end
            irq <= irq_en & done;
        end
    end

endmodule
